robo_nav_ctrl: RTL and testbench
================================

ROBO_NAV_CTRL -- requirements
Module: robo_nav_ctrl

Interface
REQ-001 Parameter TURN_CYCLES, default 8: dwell of each turn state, in clock cycles (min 1).
REQ-002 Parameter REV_CYCLES, default 12: dwell of reverse state (min 1).
REQ-003 Parameter ASP_CYCLES, default 16: dwell of suction state (min 1).
REQ-004 Parameter DEB_CYCLES, default 4: debounce stability window (min 1); used only with DEBOUNCE_EN.
REQ-005 Parameter CNT_W, default 16: dwell/debounce counter width; every cycle parameter SHALL be < 2^CNT_W.
REQ-006 clock  in  1  single system clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 liga  in  1  run enable; 0 = park robot.
REQ-009 SenE, SenF, SenD  in  1 each  left, front, right obstacle sensors; 1 = obstacle.
REQ-010 SenA  in  1  dirt sensor; 1 = dirt under robot.
REQ-011 mot_esq, mot_dir  out  2 each  left/right motor command: 00 stop, 01 forward, 10 reverse; 11 SHALL never be driven.
REQ-012 aspirador  out  1  suction motor enable.
REQ-013 estado  out  3  state code for the display decoder: PARADO 0, FRENTE 1, GIRA_ESQ 2, GIRA_DIR 3, RE 4, ASPIRAR 5.

Function
REQ-014 All outputs SHALL be registered and SHALL be decoded from the state register only (Moore).
REQ-015 Sensors SHALL pass through a sample stage (REQ-030/031); FSM decisions SHALL use sampled values only.
REQ-016 Outputs per state: PARADO 00/00/0; FRENTE 01/01/0; GIRA_ESQ 10/01/0; GIRA_DIR 01/10/0; RE 10/10/0; ASPIRAR 00/00/1 (mot_esq/mot_dir/aspirador).
REQ-017 liga=0 SHALL force PARADO on the next edge from any state, overriding all other transitions.
REQ-018 PARADO -> FRENTE when liga=1.
REQ-019 FRENTE priority, first match wins: SenA -> ASPIRAR; SenF&SenE&SenD -> RE; SenF&!SenD -> GIRA_DIR; SenF&SenD&!SenE -> GIRA_ESQ; else stay.
REQ-020 On entry to GIRA_ESQ, GIRA_DIR, RE or ASPIRAR the dwell counter SHALL load N-1 and decrement each cycle; exit occurs on the edge after counter reaches 0, giving exactly N cycles in state.
REQ-021 Dwell states SHALL ignore all sensors until expiry.
REQ-022 Exits: GIRA_ESQ, GIRA_DIR, ASPIRAR -> FRENTE; RE -> GIRA_DIR.
REQ-023 SenA still 1 on return to FRENTE SHALL re-trigger ASPIRAR after one FRENTE cycle.
REQ-024 Unused state encodings 6 and 7 SHALL recover to PARADO on the next edge.
REQ-025 Counter SHALL never wrap; it holds at 0 outside dwell states.

Reset
REQ-026 reset=1 at a rising edge SHALL set state PARADO, estado 0, motors 00, aspirador 0, dwell counter 0, sensor samples 0, debounce counters 0.
REQ-027 Reset mid-dwell SHALL abort the dwell; no residual count after release.
REQ-028 After reset release, robot SHALL remain PARADO until liga=1 is sampled.
REQ-029 reset SHALL take priority over liga and all sensors.

Configuration
REQ-030 Macro ROBO_NAV_DEBOUNCE_EN defined: each sensor's filtered value SHALL change only after the raw input differs from it for DEB_CYCLES consecutive cycles; any return to match clears that sensor's count.
REQ-031 Macro undefined: each sensor SHALL be registered once (1-cycle latency), no debounce logic or DEB_CYCLES counters instantiated.

Verification
REQ-032 Reset, liga=1, sensors 0 -> estado 0 then 1, motors 01/01, stays FRENTE indefinitely.
REQ-033 TURN_CYCLES=4, FRENTE, SenF=1 pulse (SenD=0) -> estado 3 for exactly 4 cycles, motors 01/10, then estado 1.
REQ-034 REV_CYCLES=3, TURN_CYCLES=2, SenE=SenF=SenD=1 held -> estado 4 for 3 cycles, 3 for 2 cycles, then 1 (and re-decision from sensors).
REQ-035 ASP_CYCLES=5, SenA=1 together with SenF=1 -> ASPIRAR wins: estado 5, aspirador=1 for 5 cycles, motors 00/00.
REQ-036 liga dropped mid-GIRA_DIR, then reset mid-RE -> estado 0 next edge each time, motors 00/00, counter 0.
REQ-037 With ROBO_NAV_DEBOUNCE_EN, DEB_CYCLES=4: SenF glitch 3 cycles -> no transition; SenF held 4+ cycles -> GIRA_DIR entered.

Source files
------------

// File: rtl/robo_nav_ctrl.sv
// Moore navigation controller for a cleaning robot: sampled bump/dirt sensors drive a
// six-state FSM with fixed-length dwell states. Define ROBO_NAV_DEBOUNCE_EN to debounce sensors.
module robo_nav_ctrl #(
    parameter int unsigned TURN_CYCLES = 8,
    parameter int unsigned REV_CYCLES  = 12,
    parameter int unsigned ASP_CYCLES  = 16,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       liga,
    input  logic       SenE,
    input  logic       SenF,
    input  logic       SenD,
    input  logic       SenA,
    output logic [1:0] mot_esq,
    output logic [1:0] mot_dir,
    output logic       aspirador,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        PARADO   = 3'd0,
        FRENTE   = 3'd1,
        GIRA_ESQ = 3'd2,
        GIRA_DIR = 3'd3,
        RE       = 3'd4,
        ASPIRAR  = 3'd5
    } navState_t;

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_FWD  = 2'b01;
    localparam logic [1:0] MOT_REV  = 2'b10;

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] REV_LOAD  = CNT_W'(REV_CYCLES - 1);
    localparam logic [CNT_W-1:0] ASP_LOAD  = CNT_W'(ASP_CYCLES - 1);

    // Reject dwell/debounce lengths of zero or ones that do not fit the counter.
    if (TURN_CYCLES < 1 || REV_CYCLES < 1 || ASP_CYCLES < 1 || DEB_CYCLES < 1 ||
        CNT_W < 1 || CNT_W > 31 ||
        TURN_CYCLES >= (1 << CNT_W) || REV_CYCLES >= (1 << CNT_W) ||
        ASP_CYCLES >= (1 << CNT_W) || DEB_CYCLES >= (1 << CNT_W)) begin : gBadParams
        $error("robo_nav_ctrl: cycle parameters must be in 1 .. 2**CNT_W-1");
    end

    // Bit order {A, E, F, D}
    logic [3:0] rawSen;
    logic [3:0] sensSamp;
    assign rawSen = {SenA, SenE, SenF, SenD};

`ifdef ROBO_NAV_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    logic [CNT_W-1:0] debCnt [4];

    always_ff @(posedge clock) begin
        if (reset) begin
            sensSamp <= '0;
            for (int i = 0; i < 4; i++) debCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rawSen[i] == sensSamp[i]) begin
                    debCnt[i] <= '0;
                end else if (debCnt[i] == DEB_LAST) begin
                    sensSamp[i] <= rawSen[i];
                    debCnt[i]   <= '0;
                end else begin
                    debCnt[i] <= debCnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) sensSamp <= '0;
        else       sensSamp <= rawSen;
    end
`endif

    logic senA, senE, senF, senD;
    assign {senA, senE, senF, senD} = sensSamp;

    navState_t        state, stateNext;
    logic [CNT_W-1:0] dwellCnt, cntNext;
    logic [1:0]       motEsqNext, motDirNext;
    logic             aspNext;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stateNext = state;
        cntNext   = '0;
        case (state)
            PARADO: if (liga) stateNext = FRENTE;
            FRENTE: begin
                if (senA) begin
                    stateNext = ASPIRAR;
                    cntNext   = ASP_LOAD;
                end else if (senF && senE && senD) begin
                    stateNext = RE;
                    cntNext   = REV_LOAD;
                end else if (senF && !senD) begin
                    stateNext = GIRA_DIR;
                    cntNext   = TURN_LOAD;
                end else if (senF && senD && !senE) begin
                    stateNext = GIRA_ESQ;
                    cntNext   = TURN_LOAD;
                end
            end
            GIRA_ESQ, GIRA_DIR, ASPIRAR: begin
                if (dwellCnt == '0) stateNext = FRENTE;
                else                cntNext   = dwellCnt - CNT_W'(1);
            end
            RE: begin
                if (dwellCnt == '0) begin
                    stateNext = GIRA_DIR;
                    cntNext   = TURN_LOAD;
                end else begin
                    cntNext = dwellCnt - CNT_W'(1);
                end
            end
            default: stateNext = PARADO;
        endcase

        // Parking overrides every other transition and clears any dwell in progress.
        if (!liga) begin
            stateNext = PARADO;
            cntNext   = '0;
        end

        motEsqNext = MOT_STOP;
        motDirNext = MOT_STOP;
        aspNext    = 1'b0;
        case (stateNext)
            FRENTE:   begin motEsqNext = MOT_FWD; motDirNext = MOT_FWD; end
            GIRA_ESQ: begin motEsqNext = MOT_REV; motDirNext = MOT_FWD; end
            GIRA_DIR: begin motEsqNext = MOT_FWD; motDirNext = MOT_REV; end
            RE:       begin motEsqNext = MOT_REV; motDirNext = MOT_REV; end
            ASPIRAR:  aspNext = 1'b1;
            default:  ;
        endcase
    end

    // Outputs are registered from the next-state decode so they always equal the
    // decode of the state register, one-for-one, with no combinational path to ports.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= PARADO;
            dwellCnt  <= '0;
            mot_esq   <= MOT_STOP;
            mot_dir   <= MOT_STOP;
            aspirador <= 1'b0;
            estado    <= PARADO;
        end else begin
            state     <= stateNext;
            dwellCnt  <= cntNext;
            mot_esq   <= motEsqNext;
            mot_dir   <= motDirNext;
            aspirador <= aspNext;
            estado    <= stateNext;
        end
    end

endmodule

// File: tb/tb_robo_nav_ctrl.sv
// Directed bench for robo_nav_ctrl (default build, undebounced sensors) with
// TURN_CYCLES=4, REV_CYCLES=3, ASP_CYCLES=5.
module tb_robo_nav_ctrl;

    logic       clock = 1'b0;
    logic       reset, liga, SenE, SenF, SenD, SenA;
    logic [1:0] mot_esq, mot_dir;
    logic       aspirador;
    logic [2:0] estado;

    int unsigned vecCount  = 0;
    int unsigned missCount = 0;

    robo_nav_ctrl #(
        .TURN_CYCLES(4),
        .REV_CYCLES (3),
        .ASP_CYCLES (5),
        .DEB_CYCLES (4),
        .CNT_W      (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .liga     (liga),
        .SenE     (SenE),
        .SenF     (SenF),
        .SenD     (SenD),
        .SenA     (SenA),
        .mot_esq  (mot_esq),
        .mot_dir  (mot_dir),
        .aspirador(aspirador),
        .estado   (estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Expected outputs per state code: motor codes 0 stop, 1 forward, 2 reverse.
    task automatic expectState(input string tag, input int st);
        logic [1:0] expE, expD;
        logic       expA;
        case (st)
            1:       begin expE = 2'd1; expD = 2'd1; expA = 1'b0; end
            2:       begin expE = 2'd2; expD = 2'd1; expA = 1'b0; end
            3:       begin expE = 2'd1; expD = 2'd2; expA = 1'b0; end
            4:       begin expE = 2'd2; expD = 2'd2; expA = 1'b0; end
            5:       begin expE = 2'd0; expD = 2'd0; expA = 1'b1; end
            default: begin expE = 2'd0; expD = 2'd0; expA = 1'b0; end
        endcase
        check({tag, ".estado"}, 32'(estado), 32'(st));
        check({tag, ".mot_esq"}, 32'(mot_esq), 32'(expE));
        check({tag, ".mot_dir"}, 32'(mot_dir), 32'(expD));
        check({tag, ".aspirador"}, 32'(aspirador), 32'(expA));
    endtask

    initial begin
        reset = 1'b1; liga = 1'b0;
        SenE = 1'b0; SenF = 1'b0; SenD = 1'b0; SenA = 1'b0;
        tick(2);
        expectState("reset", 0);
        check("reset.dwellCnt", 32'(dut.dwellCnt), 32'd0);
        reset = 1'b0;
        tick(2);
        expectState("idleNoLiga", 0);

        liga = 1'b1;
        tick();
        expectState("start", 1);
        tick(10);
        expectState("cruise", 1);

        // Front obstacle, right side clear: right turn for 4 cycles.
        SenF = 1'b1;
        tick();
        expectState("frontSeen", 1);
        SenF = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            expectState($sformatf("turnR%0d", i), 3);
            tick();
        end
        expectState("turnRdone", 1);

        // Front and right blocked, left clear: left turn for 4 cycles.
        SenF = 1'b1; SenD = 1'b1;
        tick();
        SenF = 1'b0; SenD = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            expectState($sformatf("turnL%0d", i), 2);
            tick();
        end
        expectState("turnLdone", 1);

        // All blocked and held: reverse 3, right turn 4, one FRENTE cycle, reverse again.
        SenE = 1'b1; SenF = 1'b1; SenD = 1'b1;
        tick();
        expectState("boxedSeen", 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            expectState($sformatf("rev%0d", i), 4);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            expectState($sformatf("revTurn%0d", i), 3);
            tick();
        end
        expectState("revDone", 1);
        tick();
        expectState("revAgain", 4);

        // Reset in the middle of the reverse dwell.
        SenE = 1'b0; SenF = 1'b0; SenD = 1'b0;
        reset = 1'b1;
        tick();
        expectState("rstMidRe", 0);
        check("rstMidRe.dwellCnt", 32'(dut.dwellCnt), 32'd0);
        reset = 1'b0;
        tick();
        expectState("afterRst", 1);
        check("afterRst.dwellCnt", 32'(dut.dwellCnt), 32'd0);

        // Drop liga in the middle of a right turn.
        SenF = 1'b1;
        tick();
        SenF = 1'b0;
        tick();
        expectState("turnBeforeDrop0", 3);
        tick();
        expectState("turnBeforeDrop1", 3);
        liga = 1'b0;
        tick();
        expectState("ligaDrop", 0);
        check("ligaDrop.dwellCnt", 32'(dut.dwellCnt), 32'd0);
        tick();
        expectState("parked", 0);
        liga = 1'b1;
        tick();
        expectState("restart", 1);

        // Dirt together with a front obstacle: suction wins for 5 cycles.
        SenA = 1'b1; SenF = 1'b1;
        tick();
        expectState("dirtSeen", 1);
        SenF = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            expectState($sformatf("asp%0d", i), 5);
            tick();
        end
        expectState("aspDone", 1);
        tick();
        expectState("aspRetrig", 5);
        SenA = 1'b0;
        tick(4);
        expectState("aspRetrigLast", 5);
        tick();
        expectState("aspRetrigDone", 1);
        tick();
        expectState("cleanFloor", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
